// File: rtl/uart_rx_frame_assembler.sv
// UART receive frame assembler: collects start/data/parity/stop samples on shift
// strobes, checks parity and framing, and holds the word behind a valid/ready handshake.
module uart_rx_frame_assembler #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 baud_clk,
  input  logic                 rst_n,
  input  logic                 data_tx,
  input  logic                 shift,
  input  logic                 ovr_clr,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned      CNT_W    = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic             PAR_EN   = (PARITY_EN != 0);
  localparam logic             PAR_ODD  = (PARITY_ODD != 0);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 start_bad_q, start_bad_d;
  logic                 par_bad_q, par_bad_d;
  logic                 frame_done;
  logic                 hold_free;

  logic [DATA_BITS-1:0] rx_data_d;
  logic                 rx_valid_d, parity_err_d, frame_err_d, overrun_d, busy_d;

  // Frame sequencing plus hold-register / overrun next-state
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    start_bad_d  = start_bad_q;
    par_bad_d    = par_bad_q;
    frame_done   = 1'b0;
    rx_data_d    = rx_data;
    rx_valid_d   = rx_valid;
    parity_err_d = parity_err;
    frame_err_d  = frame_err;
    overrun_d    = overrun;

    if (shift) begin
      unique case (state_q)
        IDLE: begin
          start_bad_d = data_tx;
          par_bad_d   = 1'b0;
          cnt_d       = '0;
          state_d     = DATA;
        end
        DATA: begin
          shreg_d = {data_tx, shreg_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) state_d = PAR_EN ? PARITY : STOP;
        end
        PARITY: begin
          par_bad_d = (^shreg_q) ^ data_tx ^ PAR_ODD;
          state_d   = STOP;
        end
        STOP: begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    hold_free = !rx_valid || rx_ready;

    if (rx_valid && rx_ready) rx_valid_d = 1'b0;

    // Stop bit sampled now feeds frame_err directly, no need to store it
    if (frame_done && hold_free) begin
      rx_data_d    = shreg_q;
      parity_err_d = PAR_EN & par_bad_q;
      frame_err_d  = start_bad_q | ~data_tx;
      rx_valid_d   = 1'b1;
    end

    if (ovr_clr) overrun_d = 1'b0;
    if (frame_done && !hold_free) overrun_d = 1'b1;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      start_bad_q <= 1'b0;
      par_bad_q   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      start_bad_q <= start_bad_d;
      par_bad_q   <= par_bad_d;
      rx_data     <= rx_data_d;
      rx_valid    <= rx_valid_d;
      parity_err  <= parity_err_d;
      frame_err   <= frame_err_d;
      overrun     <= overrun_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_assembler.sv
// Self-checking bench for uart_rx_frame_assembler: directed vector table, handshake
// corner sequences and a randomized run against a frame-level reference model.
module tb_uart_rx_frame_assembler;

  logic       baud_clk = 1'b0;
  logic       rst_n;
  logic       data_tx;
  logic       shift;
  logic       ovr_clr;
  logic       rx_ready;
  logic [7:0] rx_data, rx_data_o;
  logic       rx_valid, parity_err, frame_err, overrun, busy;
  logic       rx_valid_o, parity_err_o, frame_err_o, overrun_o, busy_o;

  int checks = 0;
  int errors = 0;
  int gap_max = 2;

  always #5 baud_clk = ~baud_clk;

  uart_rx_frame_assembler #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .baud_clk(baud_clk), .rst_n(rst_n), .data_tx(data_tx), .shift(shift),
    .ovr_clr(ovr_clr), .rx_ready(rx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  uart_rx_frame_assembler #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
    .baud_clk(baud_clk), .rst_n(rst_n), .data_tx(data_tx), .shift(shift),
    .ovr_clr(ovr_clr), .rx_ready(rx_ready), .rx_data(rx_data_o), .rx_valid(rx_valid_o),
    .parity_err(parity_err_o), .frame_err(frame_err_o), .overrun(overrun_o), .busy(busy_o)
  );

  typedef struct {
    logic       start;
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_perr;
    logic       exp_perr_odd;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pulse(input logic b);
    repeat ($urandom_range(0, gap_max)) @(negedge baud_clk);
    data_tx = b;
    shift   = 1'b1;
    @(negedge baud_clk);
    shift   = 1'b0;
    data_tx = 1'b1;
  endtask

  // Sends one frame; returns at the negedge just after the stop-strobe edge
  task automatic send_frame(input logic start, input logic [7:0] d, input logic par,
                            input logic stop, input bit rdy_at_stop, input bit clr_at_stop);
    pulse(start);
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) pulse(d[i]);
    pulse(par);
    repeat ($urandom_range(0, gap_max)) @(negedge baud_clk);
    data_tx = stop;
    shift   = 1'b1;
    if (rdy_at_stop) rx_ready = 1'b1;
    if (clr_at_stop) ovr_clr = 1'b1;
    @(negedge baud_clk);
    shift   = 1'b0;
    ovr_clr = 1'b0;
    data_tx = 1'b1;
    chk("busy_after_stop", 32'(busy), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_data"}, 32'(rx_data), 32'd0);
    chk({tag, "_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_perr"}, 32'(parity_err), 32'd0);
    chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
    chk({tag, "_ovr"}, 32'(overrun), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  logic [7:0] m_data;
  logic       m_valid, m_perr, m_perr_odd, m_ferr, m_ovr;

  initial begin
    vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; data_tx = 1'b1; shift = 1'b0; ovr_clr = 1'b0; rx_ready = 1'b1;
    repeat (3) @(negedge baud_clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge baud_clk);

    // Directed frames with the consumer always ready
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].start, vecs[i].data, vecs[i].par, vecs[i].stop, 1'b0, 1'b0);
      chk($sformatf("vec%0d_data", i), 32'(rx_data), 32'(vecs[i].data));
      chk($sformatf("vec%0d_valid", i), 32'(rx_valid), 32'd1);
      chk($sformatf("vec%0d_perr", i), 32'(parity_err), 32'(vecs[i].exp_perr));
      chk($sformatf("vec%0d_perr_odd", i), 32'(parity_err_o), 32'(vecs[i].exp_perr_odd));
      chk($sformatf("vec%0d_ferr", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
      @(negedge baud_clk);
      chk($sformatf("vec%0d_valid_one_cycle", i), 32'(rx_valid), 32'd0);
    end

    // Overrun: second frame dropped while the first is held
    rx_ready = 1'b0;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovr_first_data", 32'(rx_data), 32'h3C);
    chk("ovr_first_ovr", 32'(overrun), 32'd0);
    send_frame(1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovr_held_data", 32'(rx_data), 32'h3C);
    chk("ovr_held_valid", 32'(rx_valid), 32'd1);
    chk("ovr_set", 32'(overrun), 32'd1);
    rx_ready = 1'b1;
    @(negedge baud_clk);
    chk("ovr_drain_valid", 32'(rx_valid), 32'd0);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    @(negedge baud_clk);
    ovr_clr = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);

    // Set and clear on the same edge: set wins
    rx_ready = 1'b0;
    send_frame(1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(1'b0, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("ovr_set_wins", 32'(overrun), 32'd1);
    chk("ovr_set_wins_data", 32'(rx_data), 32'h11);
    rx_ready = 1'b1;
    ovr_clr  = 1'b1;
    @(negedge baud_clk);
    ovr_clr  = 1'b0;
    chk("ovr_set_wins_clear", 32'(overrun), 32'd0);

    // Ready rises on the exact stop-strobe edge of the next frame
    rx_ready = 1'b0;
    send_frame(1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(1'b0, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("same_edge_data", 32'(rx_data), 32'h22);
    chk("same_edge_valid", 32'(rx_valid), 32'd1);
    chk("same_edge_ovr", 32'(overrun), 32'd0);
    @(negedge baud_clk);
    chk("same_edge_drain", 32'(rx_valid), 32'd0);

    // Reset mid-frame after four strobes
    for (int i = 0; i < 4; i++) pulse(1'b0);
    chk("mid_frame_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    @(negedge baud_clk);
    rst_n = 1'b1;
    send_frame(1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_reset_data", 32'(rx_data), 32'h5A);
    chk("post_reset_valid", 32'(rx_valid), 32'd1);
    chk("post_reset_perr", 32'(parity_err), 32'd0);
    chk("post_reset_ferr", 32'(frame_err), 32'd0);
    @(negedge baud_clk);

    // Randomized frames against a frame-level model of the hold register
    m_valid = 1'b0; m_ovr = 1'b0;
    m_data = 8'h5A; m_perr = 1'b0; m_perr_odd = 1'b0; m_ferr = 1'b0;
    for (int n = 0; n < 60; n++) begin
      logic       rdy, st, sp, p;
      logic [7:0] d;
      rdy = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 7) == 0);
      sp  = ($urandom_range(0, 7) != 0);
      p   = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      rx_ready = rdy;
      send_frame(st, d, p, sp, 1'b0, 1'b0);
      if (!m_valid || rdy) begin
        m_data     = d;
        m_perr     = (^d) ^ p;
        m_perr_odd = ~((^d) ^ p);
        m_ferr     = st | ~sp;
        m_valid    = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
      chk($sformatf("rnd%0d_data", n), 32'(rx_data), 32'(m_data));
      chk($sformatf("rnd%0d_valid", n), 32'(rx_valid), 32'(m_valid));
      chk($sformatf("rnd%0d_perr", n), 32'(parity_err), 32'(m_perr));
      chk($sformatf("rnd%0d_perr_odd", n), 32'(parity_err_o), 32'(m_perr_odd));
      chk($sformatf("rnd%0d_ferr", n), 32'(frame_err), 32'(m_ferr));
      chk($sformatf("rnd%0d_ovr", n), 32'(overrun), 32'(m_ovr));
      if (rdy) m_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        ovr_clr = 1'b1;
        m_ovr   = 1'b0;
      end
      @(negedge baud_clk);
      ovr_clr = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
